// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: captures the instruction
// leaving MEM, drives the register-file write port and keeps a count of
// retired instructions.
module mem_wb_stage #(
  parameter int unsigned WORD_LEN     = 32,
  parameter int unsigned REG_ADDR_LEN = 4,
  parameter int unsigned COUNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic                    WB_EN_in,
  input  logic                    MEM_R_EN_in,
  input  logic [WORD_LEN-1:0]     ALU_res_in,
  input  logic [WORD_LEN-1:0]     dataMem_out_in,
  input  logic [REG_ADDR_LEN-1:0] dest_in,
  output logic                    WB_EN,
  output logic [REG_ADDR_LEN-1:0] WB_Dest,
  output logic [WORD_LEN-1:0]     WB_Value,
  output logic                    wb_valid,
  output logic [COUNT_W-1:0]      retired_cnt
);

  // Stage payload held between MEM and WB.
  typedef struct packed {
    logic                    valid;
    logic                    wb_en;
    logic                    mem_r_en;
    logic [WORD_LEN-1:0]     alu;
    logic [WORD_LEN-1:0]     mem;
    logic [REG_ADDR_LEN-1:0] dest;
  } stage_t;

  localparam int unsigned STAGE_W = $bits(stage_t);

  stage_t               stage_q;
  stage_t               stage_d;
  stage_t               stage_in;
  logic [COUNT_W-1:0]   cnt_q;
  logic [COUNT_W-1:0]   cnt_d;
  logic                 load;

  // Incoming instruction; controls are qualified so a bubble can never write.
  always_comb begin
    stage_in          = stage_t'({STAGE_W{1'b0}});
    stage_in.valid    = in_valid;
    stage_in.wb_en    = WB_EN_in & in_valid;
    stage_in.mem_r_en = MEM_R_EN_in & in_valid;
    stage_in.alu      = ALU_res_in;
    stage_in.mem      = dataMem_out_in;
    stage_in.dest     = dest_in;
  end

  // Next stage contents: flush beats stall, stall beats load.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (flush) begin
      stage_d = stage_t'({STAGE_W{1'b0}});
    end else if (!stall) begin
      load    = 1'b1;
      stage_d = stage_in;
      if (in_valid) begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
    end
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= stage_t'({STAGE_W{1'b0}});
    end else begin
      stage_q <= stage_d;
    end
  end

  // Retired-instruction counter; wraps naturally at full scale.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Writeback port decoded purely from the stage register.
  always_comb begin
    WB_EN       = stage_q.wb_en & stage_q.valid;
    WB_Dest     = stage_q.dest;
    WB_Value    = stage_q.mem_r_en ? stage_q.mem : stage_q.alu;
    wb_valid    = stage_q.valid;
    retired_cnt = cnt_q;
  end

  logic unused_load;
  assign unused_load = load;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage, counter width reduced to 4 for wrap checks.
module tb_mem_wb_stage;

  localparam int unsigned WL = 32;
  localparam int unsigned RL = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic          WB_EN_in;
  logic          MEM_R_EN_in;
  logic [WL-1:0] ALU_res_in;
  logic [WL-1:0] dataMem_out_in;
  logic [RL-1:0] dest_in;
  logic          WB_EN;
  logic [RL-1:0] WB_Dest;
  logic [WL-1:0] WB_Value;
  logic          wb_valid;
  logic [CW-1:0] retired_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_stage #(.WORD_LEN(WL), .REG_ADDR_LEN(RL), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in),
    .ALU_res_in(ALU_res_in), .dataMem_out_in(dataMem_out_in), .dest_in(dest_in),
    .WB_EN(WB_EN), .WB_Dest(WB_Dest), .WB_Value(WB_Value),
    .wb_valid(wb_valid), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic fl, input logic v,
                       input logic we, input logic mr, input logic [WL-1:0] alu,
                       input logic [WL-1:0] mem, input logic [RL-1:0] d);
    rst = r; stall = st; flush = fl; in_valid = v; WB_EN_in = we;
    MEM_R_EN_in = mr; ALU_res_in = alu; dataMem_out_in = mem; dest_in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic we, input logic [RL-1:0] d,
                           input logic [WL-1:0] val, input logic v, input logic [CW-1:0] c);
    check({tag, ".WB_EN"}, 32'(WB_EN), 32'(we));
    check({tag, ".WB_Dest"}, 32'(WB_Dest), 32'(d));
    check({tag, ".WB_Value"}, WB_Value, val);
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
    check({tag, ".cnt"}, 32'(retired_cnt), 32'(c));
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1111_2222, 4'hF);
    tick();
    check_all("reset", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);

    // Idle after reset release.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    tick();
    check_all("idle", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);

    // Bubble with live controls: no write, no count, data still loaded, load flag masked.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0055, 32'h0000_0099, 4'd9);
    tick();
    check_all("bubble", 1'b0, 4'd9, 32'h0000_0055, 1'b0, 4'd0);

    // ALU writeback.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'hDEAD_BEEF, 4'd5);
    tick();
    check_all("alu_wb", 1'b1, 4'd5, 32'h0000_1234, 1'b1, 4'd1);

    // Load writeback.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'd5);
    tick();
    check_all("load_wb", 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b1, 4'd2);

    // Store-like: valid but no register write.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0BAD_F00D, 4'd2);
    tick();
    check_all("store", 1'b0, 4'd2, 32'h0000_4000, 1'b1, 4'd3);

    // Stall: hold dest=3 for three cycles while dest=7 waits at the input.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAA_0001, 32'h0, 4'd3);
    tick();
    check_all("pre_stall", 1'b1, 4'd3, 32'hAAAA_0001, 1'b1, 4'd4);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0777, 32'h0, 4'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("stall%0d", i), 1'b1, 4'd3, 32'hAAAA_0001, 1'b1, 4'd4);
    end
    stall = 1'b0;
    tick();
    check_all("unstall", 1'b1, 4'd7, 32'h0000_0777, 1'b1, 4'd5);

    // Stall and flush together with a valid instruction at the input.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1357_9BDF, 32'h2468_ACE0, 4'd6);
    tick();
    check_all("flush", 1'b0, 4'd0, 32'h0, 1'b0, 4'd5);

    // Counter wrap from a fresh reset.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    tick();
    check("wrap_reset.cnt", 32'(retired_cnt), 32'd0);
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'(i), 32'h0, 4'(i));
      tick();
      if (i == 15) check("wrap15.cnt", 32'(retired_cnt), 32'd15);
      if (i == 16) check("wrap16.cnt", 32'(retired_cnt), 32'd0);
      if (i == 17) check("wrap17.cnt", 32'(retired_cnt), 32'd1);
    end
    check("wrap17.WB_Value", WB_Value, 32'd17);

    // Reset in the middle of a stream of valid loads.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_00A0, 32'h0, 4'd1);
    tick();
    check("mid.cnt", 32'(retired_cnt), 32'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_00A1, 32'h0, 4'd2);
    tick();
    check_all("mid_reset", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hCAFE_0001, 4'd4);
    tick();
    check_all("post_reset", 1'b1, 4'd4, 32'hCAFE_0001, 1'b1, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback stage of the 5-stage core, directly downstream of the memory stage. Each cycle it captures the ALU result, data-memory read data, destination register and writeback controls leaving MEM, then drives the register-file write port and the writeback forwarding path. It supports pipeline stall and flush, and keeps a retired-instruction counter for debug and performance checks.

## Interface
- WORD_LEN, 32, datapath width (matches `WORD_LEN`)
- REG_ADDR_LEN, 4, register-file address width
- COUNT_W, 32, retired-instruction counter width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk
- stall  in  1  hold all stage registers unchanged this cycle
- flush  in  1  replace stage contents with a bubble this cycle
- in_valid  in  1  MEM stage holds a real instruction
- WB_EN_in  in  1  instruction writes the register file
- MEM_R_EN_in  in  1  instruction is a load
- ALU_res_in  in  WORD_LEN  ALU result / address from MEM stage
- dataMem_out_in  in  WORD_LEN  data-memory read data from MEM stage
- dest_in  in  REG_ADDR_LEN  destination register number
- WB_EN  out  1  register-file write enable
- WB_Dest  out  REG_ADDR_LEN  register-file write address
- WB_Value  out  WORD_LEN  register-file write data
- wb_valid  out  1  stage holds a valid instruction
- retired_cnt  out  COUNT_W  count of instructions captured into the stage

## Operation
- Internal registers: valid_q, wb_en_q, mem_r_en_q, alu_q, mem_q, dest_q, cnt_q.
- Update priority per rising edge: reset > flush > stall > load.
  - rst=0: all internal registers cleared to 0.
  - flush=1 (rst=1): valid_q, wb_en_q, mem_r_en_q cleared; alu_q, mem_q, dest_q cleared to 0; cnt_q unchanged. Flush overrides stall.
  - stall=1, flush=0: all registers hold, including cnt_q.
  - otherwise: load all *_in into the registers; valid_q<=in_valid; wb_en_q<=WB_EN_in&in_valid; mem_r_en_q<=MEM_R_EN_in&in_valid.
- Counter: cnt_q increments by 1 on a load cycle with in_valid=1; wraps from 2^COUNT_W-1 to 0; never saturates.
- Outputs (combinational from registers only, no input-to-output path):
  - WB_EN = wb_en_q & valid_q.
  - WB_Dest = dest_q.
  - WB_Value = mem_r_en_q ? mem_q : alu_q (full WORD_LEN, no extension or alignment).
  - wb_valid = valid_q; retired_cnt = cnt_q.
- Bubble (in_valid=0) loads harmlessly: WB_EN=0 next cycle regardless of WB_EN_in; data fields still loaded but unused.

## Timing
- Latency: 1 cycle from MEM-stage inputs to WB outputs.
- Reset values: WB_EN=0, WB_Dest=0, WB_Value=0, wb_valid=0, retired_cnt=0; visible after the first edge with rst=0.
- Reset mid-operation: in-flight instruction discarded, counter cleared, same edge.
- Stall for N cycles: outputs constant for N cycles; WB_EN stays asserted if it was — the register file rewriting the same value is permitted.
- Simultaneous stall+flush: flush behaviour.
- Register file writes WB_Value on the clock edge following the cycle WB_EN is high; this block performs no write-before-read bypass.

## Test plan
- Reset: drive rst=0 one edge with arbitrary inputs -> all outputs 0; release rst, idle inputs (in_valid=0) -> outputs remain 0, retired_cnt=0.
- ALU writeback: in_valid=1, WB_EN_in=1, MEM_R_EN_in=0, ALU_res_in=0x0000_1234, dataMem_out_in=0xDEAD_BEEF, dest_in=5 -> next cycle WB_EN=1, WB_Dest=5, WB_Value=0x0000_1234, retired_cnt=1.
- Load writeback: same but MEM_R_EN_in=1 -> WB_Value=0xDEAD_BEEF; store-like (WB_EN_in=0, in_valid=1) -> WB_EN=0, wb_valid=1, counter +1.
- Stall: load dest=3 value 0xAAAA_0001, then stall=1 for 3 cycles with new inputs dest=7 -> outputs hold dest=3/0xAAAA_0001, counter unchanged; after release the dest=7 instruction appears.
- Flush priority: stall=1 and flush=1 same cycle with valid stage -> next cycle WB_EN=0, wb_valid=0, WB_Value=0, counter unchanged.
- Counter wrap (COUNT_W=4): 17 consecutive valid loads -> retired_cnt reads 15 after 15th, 0 after 16th, 1 after 17th; synchronous reset mid-sequence returns it to 0 on that edge.
